// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, sticky trap on timeout or illegal opcode, and an instret counter.
module riscv_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [31:0]      instret_q, instret_d;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:7];

  // State, latched opcode, wait counter, trap cause and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      wait_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and control strobes from state and latched opcode.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        opcode_d = instruction[6:0];
        case (instruction[6:0])
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC: begin
        case (opcode_q)
          OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            alu_op  = 2'b00;
            state_d = S_MEM;
            wait_d  = '0;
          end
          OP_BRANCH: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = branch_taken;
            state_d  = S_FETCH;
            wait_d   = '0;
          end
          OP_I: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          default: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_STORE);
        if (dmem_ack) begin
          if (opcode_q == OP_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
            wait_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_q == OP_LOAD);
        pc_write   = 1'b1;
        state_d    = S_FETCH;
        wait_d     = '0;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: state_d = S_IDLE;
    endcase

    instret_d = pc_write ? instret_q + 32'd1 : instret_q;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: each driven cycle pushes its expected
// strobes and instret; a negedge monitor pops and compares.
module tb_riscv_mc_ctrl;

  localparam int unsigned TO = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_write, dmem_req, dmem_we, alu_src;
  logic [1:0]  alu_op;
  logic        pc_write, pc_src, reg_write, mem_to_reg, trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  riscv_mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_write     (ir_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [13:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = '0;
  logic [13:0] got_ctl;

  assign got_ctl = {imem_req, ir_write, dmem_req, dmem_we, alu_src, alu_op,
                    pc_write, pc_src, reg_write, mem_to_reg, trap, trap_cause};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // bit 6 of the packed vector is pc_write
  function automatic logic [13:0] mk(bit imr, bit irw, bit dr, bit dwe, bit asrc,
                                     logic [1:0] aop, bit pcw, bit pcs, bit rw,
                                     bit m2r, bit tr, logic [1:0] tc);
    return {imr, irw, dr, dwe, asrc, aop, pcw, pcs, rw, m2r, tr, tc};
  endfunction

  function automatic logic [13:0] exp_exec(logic [6:0] op, bit bt);
    case (op)
      OP_R:      return mk(0,0,0,0,0,2'b10,0,0,0,0,0,2'b00);
      OP_I:      return mk(0,0,0,0,1,2'b10,0,0,0,0,0,2'b00);
      OP_LOAD,
      OP_STORE:  return mk(0,0,0,0,1,2'b00,0,0,0,0,0,2'b00);
      default:   return mk(0,0,0,0,0,2'b01,1,bt,0,0,0,2'b00);
    endcase
  endfunction

  // Monitor: compare mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".ctl"}, 32'(got_ctl), 32'(e.ctl));
      check({e.tag, ".instret"}, instret, e.ir);
    end
  end

  // Called at posedge+1: drive one cycle, queue its expectation, advance.
  task automatic step(input string tag, input bit ia, input bit da, input bit bt,
                      input logic [13:0] e);
    imem_ack     = ia;
    dmem_ack     = da;
    branch_taken = bt;
    sb.push_back('{tag, e, exp_instret});
    if (e[6]) exp_instret = exp_instret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".ctl"}, 32'(got_ctl), 32'd0);
    check({tag, ".instret"}, instret, 32'd0);
    exp_instret = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One instruction starting in FETCH. A wait count of TO ends the task
  // in the cycle the timeout trap is expected to appear.
  task automatic run(input logic [6:0] op, input int unsigned fwait,
                     input int unsigned mwait, input bit bt);
    bit ld, st, br;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    br = (op == OP_BRANCH);
    for (int unsigned i = 0; i < fwait; i++)
      step("fetch_wait", 0, 1, 0, mk(1,0,0,0,0,2'b00,0,0,0,0,0,2'b00));
    if (fwait >= TO) return;
    instruction = {25'h0155AA5, op};
    step("fetch_ack", 1, 1, 0, mk(1,1,0,0,0,2'b00,0,0,0,0,0,2'b00));
    step("decode", 1, 1, 1, '0);
    if (!(ld || st || br || op == OP_R || op == OP_I)) return;
    step("exec", 1, 1, br ? bt : 1'b0, exp_exec(op, bt));
    if (ld || st) begin
      for (int unsigned i = 0; i < mwait; i++)
        step("mem_wait", 1, 0, 0, mk(0,0,1,st,0,2'b00,0,0,0,0,0,2'b00));
      if (mwait >= TO) return;
      step("mem_ack", 1, 1, 0, mk(0,0,1,st,0,2'b00,st,0,0,0,0,2'b00));
    end
    if (!st && !br)
      step("wb", 1, 1, 0, mk(0,0,0,0,0,2'b00,1,0,1,ld,0,2'b00));
  endtask

  task automatic trap_cycles(input int unsigned n, input logic [1:0] cause);
    for (int unsigned i = 0; i < n; i++)
      step("trap", 1, 1, 1, mk(0,0,0,0,0,2'b00,0,0,0,0,1,cause));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    pulse_reset("reset0");
    step("idle", 1, 1, 0, '0);

    // Basic mix: R, load with 3 MEM cycles, I-ALU with a fetch wait,
    // store, taken/untaken branches, store with one MEM wait.
    run(OP_R, 0, 0, 0);
    run(OP_LOAD, 0, 2, 0);
    run(OP_I, 1, 0, 0);
    run(OP_STORE, 0, 0, 0);
    run(OP_BRANCH, 0, 0, 1);
    run(OP_BRANCH, 0, 0, 0);
    run(OP_STORE, 0, 1, 0);

    // Illegal opcode: sticky trap despite acks.
    run(OP_BAD, 0, 0, 0);
    trap_cycles(50, 2'b01);
    pulse_reset("reset_trap");
    step("idle", 1, 1, 0, '0);

    // Fetch timeout.
    run(OP_R, TO, 0, 0);
    trap_cycles(3, 2'b10);
    pulse_reset("reset_ftmo");
    step("idle", 1, 1, 0, '0);

    // Ack on the last allowed fetch cycle wins.
    run(OP_R, TO - 1, 0, 0);
    // Ack on the last allowed MEM cycle wins.
    run(OP_LOAD, 0, TO - 1, 0);
    // Data-memory timeout.
    run(OP_LOAD, 0, TO, 0);
    trap_cycles(3, 2'b11);
    pulse_reset("reset_dtmo");
    step("idle", 1, 1, 0, '0);

    // Reset mid-MEM, asserted after the mid-cycle sample.
    run(OP_R, 0, 0, 0);
    instruction = {25'h0, OP_LOAD};
    step("fetch_ack", 1, 0, 0, mk(1,1,0,0,0,2'b00,0,0,0,0,0,2'b00));
    step("decode", 0, 0, 0, '0);
    step("exec", 0, 0, 0, exp_exec(OP_LOAD, 0));
    step("mem_wait", 0, 0, 0, mk(0,0,1,0,0,2'b00,0,0,0,0,0,2'b00));
    #5;
    pulse_reset("reset_mem");
    step("idle", 0, 0, 0, '0);
    run(OP_I, 0, 0, 0);

    // instret wrap from all-ones.
    pulse_reset("reset_wrap");
    force dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    step("idle", 0, 0, 0, '0);
    release dut.instret_q;
    run(OP_R, 0, 0, 0);
    run(OP_BRANCH, 0, 0, 1);
    step("fetch_end", 0, 0, 0, mk(1,0,0,0,0,2'b00,0,0,0,0,0,2'b00));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
